// File: rtl/stage_4_mem_access.sv
// stage_4_mem_access: memory-access pipeline stage downstream of execute.
//
// Captures the EX results into an EX/MEM register, runs loads and stores against a req/ack
// data-memory port, formats load data, and hands one result per instruction to write-back.
// Upstream is stalled while a memory access is outstanding.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses complete immediately with Misaligned_MEM=1
//               and never reach the memory port.
//   undefined : Misaligned_MEM is tied low; the low address bits are ignored by the access size.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   Valid_EX .. Reg_Write_EX instruction fields from the execute stage
//   Stall_MEM                upstream must hold its outputs (high while an access is in flight)
//   Dmem_*                   data-memory request port (Req held until Ack)
//   Valid_MEM .. Rd_MEM      one-cycle write-back result pulse and its destination
//   Reg_Write_MEM            write enable, only ever high together with Valid_MEM
//   Bus_Err_MEM              pulses with Valid_MEM when the memory never acknowledged
//   Misaligned_MEM           pulses with Valid_MEM on a trapped misaligned access

module stage_4_mem_access #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // Execute stage
  input  logic        Valid_EX,
  input  logic [31:0] Alu_Out_EX,
  input  logic [31:0] Address_EX,
  input  logic [31:0] Store_Data_EX,
  input  logic        Mem_Read_EX,
  input  logic        Mem_Write_EX,
  input  logic [2:0]  Funct3_EX,
  input  logic [4:0]  Rd_EX,
  input  logic        Reg_Write_EX,
  output logic        Stall_MEM,
  // Data memory
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [31:0] Dmem_Wdata,
  output logic [3:0]  Dmem_Be,
  input  logic        Dmem_Ack,
  input  logic [31:0] Dmem_Rdata,
  // Write-back
  output logic        Valid_MEM,
  output logic [31:0] Wb_Data_MEM,
  output logic [4:0]  Rd_MEM,
  output logic        Reg_Write_MEM,
  output logic        Bus_Err_MEM,
  output logic        Misaligned_MEM
);

  localparam int unsigned CntW = $clog2(MAX_WAIT);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Reserved encodings fall through to a word access.
  function automatic size_e decode_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: decode_size = SzByte;
      3'b001, 3'b101: decode_size = SzHalf;
      default:        decode_size = SzWord;
    endcase
  endfunction

  // Stage state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // EX/MEM register fields needed after capture
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      byte_off_q, byte_off_d;

  // Registered memory-port outputs
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;

  // Registered write-back outputs
  logic            valid_q, valid_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            reg_write_mem_q, reg_write_mem_d;
  logic            bus_err_q, bus_err_d;
  logic            misal_q, misal_d;

  // Combinational helpers
  logic            ex_mem_op;
  logic            ex_misaligned;
  size_e           ex_size;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            ld_sext;
  logic [31:0]     ld_data;

  assign ex_mem_op = Mem_Read_EX | Mem_Write_EX;
  assign ex_size   = decode_size(Funct3_EX);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    ex_misaligned = 1'b0;
    if (ex_mem_op) begin
      case (ex_size)
        SzHalf:  ex_misaligned = Address_EX[0];
        SzWord:  ex_misaligned = |Address_EX[1:0];
        default: ex_misaligned = 1'b0;
      endcase
    end
  end
`else
  assign ex_misaligned = 1'b0;
`endif

  // Store lane steering; the data is replicated so every enabled lane carries it.
  always_comb begin
    st_wdata = Store_Data_EX;
    st_be    = 4'b1111;
    case (ex_size)
      SzByte: begin
        st_wdata = {4{Store_Data_EX[7:0]}};
        st_be    = 4'b0001 << Address_EX[1:0];
      end
      SzHalf: begin
        st_wdata = {2{Store_Data_EX[15:0]}};
        st_be    = 4'b0011 << {Address_EX[1], 1'b0};
      end
      default: begin
        st_wdata = Store_Data_EX;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension, using the captured offset and size.
  always_comb begin
    case (byte_off_q)
      2'd0:    ld_byte = Dmem_Rdata[7:0];
      2'd1:    ld_byte = Dmem_Rdata[15:8];
      2'd2:    ld_byte = Dmem_Rdata[23:16];
      default: ld_byte = Dmem_Rdata[31:24];
    endcase
    ld_half = byte_off_q[1] ? Dmem_Rdata[31:16] : Dmem_Rdata[15:0];
    ld_sext = ~funct3_q[2];
    case (decode_size(funct3_q))
      SzByte:  ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_data = Dmem_Rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_d            = rd_q;
    reg_write_d     = reg_write_q;
    is_load_d       = is_load_q;
    funct3_d        = funct3_q;
    byte_off_d      = byte_off_q;
    req_d           = req_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    wb_data_d       = wb_data_q;
    // Result flags are pulses: low unless a result completes this cycle.
    valid_d         = 1'b0;
    reg_write_mem_d = 1'b0;
    bus_err_d       = 1'b0;
    misal_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Valid_EX) begin
          rd_d        = Rd_EX;
          reg_write_d = Reg_Write_EX;
          is_load_d   = Mem_Read_EX;
          funct3_d    = Funct3_EX;
          byte_off_d  = Address_EX[1:0];
          if (!ex_mem_op) begin
            valid_d         = 1'b1;
            wb_data_d       = Alu_Out_EX;
            reg_write_mem_d = Reg_Write_EX;
          end else if (ex_misaligned) begin
            valid_d   = 1'b1;
            misal_d   = 1'b1;
            wb_data_d = 32'h0;
          end else begin
            state_d = StBusy;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = Mem_Write_EX;
            addr_d  = {Address_EX[31:2], 2'b00};
            wdata_d = st_wdata;
            be_d    = Mem_Read_EX ? 4'b1111 : st_be;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        // Ack wins over a timeout landing in the same cycle.
        if (Dmem_Ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          valid_d = 1'b1;
          if (is_load_q) begin
            wb_data_d       = ld_data;
            reg_write_mem_d = reg_write_q;
          end
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          bus_err_d = 1'b1;
          wb_data_d = 32'h0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      is_load_q       <= 1'b0;
      funct3_q        <= '0;
      byte_off_q      <= '0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      valid_q         <= 1'b0;
      wb_data_q       <= '0;
      reg_write_mem_q <= 1'b0;
      bus_err_q       <= 1'b0;
      misal_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rd_q            <= rd_d;
      reg_write_q     <= reg_write_d;
      is_load_q       <= is_load_d;
      funct3_q        <= funct3_d;
      byte_off_q      <= byte_off_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
      valid_q         <= valid_d;
      wb_data_q       <= wb_data_d;
      reg_write_mem_q <= reg_write_mem_d;
      bus_err_q       <= bus_err_d;
      misal_q         <= misal_d;
    end
  end

  assign Stall_MEM      = (state_q == StBusy);
  assign Dmem_Req       = req_q;
  assign Dmem_We        = we_q;
  assign Dmem_Addr      = addr_q;
  assign Dmem_Wdata     = wdata_q;
  assign Dmem_Be        = be_q;
  assign Valid_MEM      = valid_q;
  assign Wb_Data_MEM    = wb_data_q;
  // The EX/MEM destination is not overwritten until the result has been presented.
  assign Rd_MEM         = rd_q;
  assign Reg_Write_MEM  = reg_write_mem_q;
  assign Bus_Err_MEM    = bus_err_q;
  assign Misaligned_MEM = misal_q;

endmodule

// File: tb/tb_stage_4_mem_access.sv
// Randomized bench for stage_4_mem_access with a behavioural expectation model.
module tb_stage_4_mem_access;

  localparam int unsigned MaxWait = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_EX;
  logic [31:0] Alu_Out_EX;
  logic [31:0] Address_EX;
  logic [31:0] Store_Data_EX;
  logic        Mem_Read_EX;
  logic        Mem_Write_EX;
  logic [2:0]  Funct3_EX;
  logic [4:0]  Rd_EX;
  logic        Reg_Write_EX;
  logic        Stall_MEM;
  logic        Dmem_Req;
  logic        Dmem_We;
  logic [31:0] Dmem_Addr;
  logic [31:0] Dmem_Wdata;
  logic [3:0]  Dmem_Be;
  logic        Dmem_Ack;
  logic [31:0] Dmem_Rdata;
  logic        Valid_MEM;
  logic [31:0] Wb_Data_MEM;
  logic [4:0]  Rd_MEM;
  logic        Reg_Write_MEM;
  logic        Bus_Err_MEM;
  logic        Misaligned_MEM;

  int n_checks = 0;
  int n_fail   = 0;

  stage_4_mem_access #(
    .MAX_WAIT(MaxWait)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .Valid_EX      (Valid_EX),
    .Alu_Out_EX    (Alu_Out_EX),
    .Address_EX    (Address_EX),
    .Store_Data_EX (Store_Data_EX),
    .Mem_Read_EX   (Mem_Read_EX),
    .Mem_Write_EX  (Mem_Write_EX),
    .Funct3_EX     (Funct3_EX),
    .Rd_EX         (Rd_EX),
    .Reg_Write_EX  (Reg_Write_EX),
    .Stall_MEM     (Stall_MEM),
    .Dmem_Req      (Dmem_Req),
    .Dmem_We       (Dmem_We),
    .Dmem_Addr     (Dmem_Addr),
    .Dmem_Wdata    (Dmem_Wdata),
    .Dmem_Be       (Dmem_Be),
    .Dmem_Ack      (Dmem_Ack),
    .Dmem_Rdata    (Dmem_Rdata),
    .Valid_MEM     (Valid_MEM),
    .Wb_Data_MEM   (Wb_Data_MEM),
    .Rd_MEM        (Rd_MEM),
    .Reg_Write_MEM (Reg_Write_MEM),
    .Bus_Err_MEM   (Bus_Err_MEM),
    .Misaligned_MEM(Misaligned_MEM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    int          sz;
    sz = size_bytes(f3);
    if (sz == 1) begin
      v = (w >> (8 * int'(a))) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = size_bytes(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    int         sz;
    int         lo;
    sz = size_bytes(f3);
    be = 4'b0000;
    if (sz == 1) begin
      be[a] = 1'b1;
    end else if (sz == 2) begin
      lo = 2 * int'(a[1]);
      be[lo]     = 1'b1;
      be[lo + 1] = 1'b1;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic bit exp_trap(input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    int sz;
    sz = size_bytes(f3);
    if (sz == 2) return a[0];
    if (sz == 4) return a != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    Valid_EX      = 1'b0;
    Mem_Read_EX   = 1'b0;
    Mem_Write_EX  = 1'b0;
    Alu_Out_EX    = $urandom;
    Address_EX    = $urandom;
    Store_Data_EX = $urandom;
    Funct3_EX     = 3'($urandom);
    Rd_EX         = 5'($urandom);
    Reg_Write_EX  = 1'($urandom);
  endtask

  // Called just after a falling edge with the stage idle; returns just after a falling edge.
  // ack_after: BUSY cycle (1-based) in which Dmem_Ack is raised; > MaxWait means never.
  task automatic run_op(input bit is_ld, input bit is_st, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input bit rw,
                        input int ack_after, input logic [31:0] rdata);
    bit done;
    int n;
    Valid_EX      = 1'b1;
    Mem_Read_EX   = is_ld;
    Mem_Write_EX  = is_st;
    Funct3_EX     = f3;
    Alu_Out_EX    = alu;
    Address_EX    = addr;
    Store_Data_EX = sdata;
    Rd_EX         = rd;
    Reg_Write_EX  = rw;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    if (!is_ld && !is_st) begin
      check_eq("alu_valid", 32'(Valid_MEM), 32'd1);
      check_eq("alu_wb", Wb_Data_MEM, alu);
      check_eq("alu_rd", 32'(Rd_MEM), 32'(rd));
      check_eq("alu_rw", 32'(Reg_Write_MEM), 32'(rw));
      check_eq("alu_stall", 32'(Stall_MEM), 32'd0);
    end else if (exp_trap(f3, addr[1:0])) begin
      check_eq("mis_valid", 32'(Valid_MEM), 32'd1);
      check_eq("mis_flag", 32'(Misaligned_MEM), 32'd1);
      check_eq("mis_rw", 32'(Reg_Write_MEM), 32'd0);
      check_eq("mis_req", 32'(Dmem_Req), 32'd0);
      check_eq("mis_stall", 32'(Stall_MEM), 32'd0);
    end else begin
      check_eq("req_we", 32'(Dmem_We), 32'(is_st));
      check_eq("req_addr", Dmem_Addr, {addr[31:2], 2'b00});
      check_eq("req_be", 32'(Dmem_Be), is_st ? 32'(exp_be(f3, addr[1:0])) : 32'hF);
      if (is_st) check_eq("req_wdata", Dmem_Wdata, exp_wdata(f3, sdata));
      done = 1'b0;
      n    = 0;
      while (!done) begin
        n++;
        check_eq("busy_req", 32'(Dmem_Req), 32'd1);
        check_eq("busy_stall", 32'(Stall_MEM), 32'd1);
        check_eq("busy_valid", 32'(Valid_MEM), 32'd0);
        Dmem_Ack   = (n == ack_after);
        Dmem_Rdata = rdata;
        @(posedge clk);
        @(negedge clk);
        Dmem_Ack   = 1'b0;
        Dmem_Rdata = $urandom;
        if (n == ack_after) begin
          done = 1'b1;
          check_eq("done_valid", 32'(Valid_MEM), 32'd1);
          check_eq("done_req", 32'(Dmem_Req), 32'd0);
          check_eq("done_stall", 32'(Stall_MEM), 32'd0);
          check_eq("done_berr", 32'(Bus_Err_MEM), 32'd0);
          check_eq("done_rd", 32'(Rd_MEM), 32'(rd));
          if (is_ld) begin
            check_eq("ld_data", Wb_Data_MEM, exp_load(f3, addr[1:0], rdata));
            check_eq("ld_rw", 32'(Reg_Write_MEM), 32'(rw));
          end else begin
            check_eq("st_rw", 32'(Reg_Write_MEM), 32'd0);
          end
        end else if (n == int'(MaxWait)) begin
          done = 1'b1;
          check_eq("to_valid", 32'(Valid_MEM), 32'd1);
          check_eq("to_berr", 32'(Bus_Err_MEM), 32'd1);
          check_eq("to_rw", 32'(Reg_Write_MEM), 32'd0);
          check_eq("to_req", 32'(Dmem_Req), 32'd0);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(Valid_MEM), 32'd0);
    check_eq({tag, "_req"}, 32'(Dmem_Req), 32'd0);
    check_eq({tag, "_stall"}, 32'(Stall_MEM), 32'd0);
    check_eq({tag, "_we"}, 32'(Dmem_We), 32'd0);
    check_eq({tag, "_addr"}, Dmem_Addr, 32'd0);
    check_eq({tag, "_wdata"}, Dmem_Wdata, 32'd0);
    check_eq({tag, "_be"}, 32'(Dmem_Be), 32'd0);
    check_eq({tag, "_wb"}, Wb_Data_MEM, 32'd0);
    check_eq({tag, "_rd"}, 32'(Rd_MEM), 32'd0);
    check_eq({tag, "_rw"}, 32'(Reg_Write_MEM), 32'd0);
    check_eq({tag, "_berr"}, 32'(Bus_Err_MEM), 32'd0);
    check_eq({tag, "_mis"}, 32'(Misaligned_MEM), 32'd0);
  endtask

  initial begin
    logic [31:0] burst_val [5];
    logic [2:0]  ld_f3 [8];
    logic [2:0]  st_f3 [4];
    int          kind;
    int          ack;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
    rst        = 1'b1;
    Dmem_Ack   = 1'b0;
    Dmem_Rdata = 32'h0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_op(0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 1, 0, 32'h0);
    run_op(1, 0, 3'b000, 32'h0, 32'h103, 32'h0, 5'd7, 1, 3, 32'h80FF_FFFF);
    run_op(1, 0, 3'b100, 32'h0, 32'h103, 32'h0, 5'd8, 1, 3, 32'h80FF_FFFF);
    run_op(0, 1, 3'b001, 32'h0, 32'h22, 32'hDEAD_BEEF, 5'd9, 1, 1, 32'h0);
    run_op(1, 0, 3'b010, 32'h0, 32'h200, 32'h0, 5'd10, 1, MaxWait + 1, 32'h0);
    run_op(1, 0, 3'b010, 32'h0, 32'h204, 32'h0, 5'd11, 1, MaxWait, 32'hCAFE_F00D);
    run_op(1, 0, 3'b010, 32'h0, 32'h102, 32'h0, 5'd12, 1, 2, 32'h1357_9BDF);

    // Reset during the second BUSY cycle discards the access
    Valid_EX    = 1'b1;
    Mem_Read_EX = 1'b1;
    Funct3_EX   = 3'b010;
    Address_EX  = 32'h300;
    Rd_EX       = 5'd13;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    run_op(0, 0, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0, 5'd14, 1, 0, 32'h0);

    // Back-to-back ALU results, one per cycle
    for (int i = 0; i < 5; i++) begin
      burst_val[i]  = $urandom;
      Valid_EX      = 1'b1;
      Mem_Read_EX   = 1'b0;
      Mem_Write_EX  = 1'b0;
      Alu_Out_EX    = burst_val[i];
      Rd_EX         = 5'(i + 1);
      Reg_Write_EX  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("burst_valid", 32'(Valid_MEM), 32'd1);
      check_eq("burst_wb", Wb_Data_MEM, burst_val[i]);
      check_eq("burst_rd", 32'(Rd_MEM), 32'(i + 1));
    end
    drive_idle();

    // Randomized mix
    for (int i = 0; i < 250; i++) begin
      kind = int'($urandom_range(0, 2));
      ack  = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, MaxWait + 1));
      if (kind == 0) begin
        run_op(0, 0, 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
               1'($urandom), 0, 32'h0);
      end else if (kind == 1) begin
        run_op(1, 0, ld_f3[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
               5'($urandom), 1'($urandom), ack, $urandom);
      end else begin
        run_op(0, 1, st_f3[$urandom_range(0, 3)], $urandom, $urandom, $urandom,
               5'($urandom), 1'($urandom), ack, $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_valid", 32'(Valid_MEM), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
